// File: rtl/gcd_pkg.sv
// Shared types and helpers for the GCD arbiter: FSM state encoding, default width,
// and a two's-complement magnitude helper wide enough for any supported operand width.
package gcd_pkg;

  localparam int GCD_W = 16;
  localparam int ABS_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Callers sign-extend into ABS_W first, so the most negative W-bit value has headroom.
  function automatic logic [ABS_W-1:0] abs_mag(input logic signed [ABS_W-1:0] v);
    return v[ABS_W-1] ? ABS_W'(-v) : ABS_W'(v);
  endfunction

endpackage

// File: rtl/gcd_arbiter_if.sv
// Request/result bundle between client blocks (master) and the GCD arbiter (slave).
// Requests are levels held with operands until ack; results are a one-cycle strobe.
interface gcd_arbiter_if
  import gcd_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = GCD_W
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] xi;
  logic [N_REQ*W-1:0] yi;
  logic [N_REQ-1:0]   ack;
  logic               busy;
  logic               res_valid;
  logic [ID_W-1:0]    res_id;
  logic [W-1:0]       res_data;
  logic               res_err;

  modport master (
    output req, xi, yi,
    input  ack, busy, res_valid, res_id, res_data, res_err
  );

  modport slave (
    input  req, xi, yi,
    output ack, busy, res_valid, res_id, res_data, res_err
  );

endinterface

// File: rtl/gcd_core.sv
// Subtract-based GCD datapath: one subtraction per enabled cycle, flags are combinational
// on the registered operands; no backpressure, the controller owns sequencing.
module gcd_core
  import gcd_pkg::*;
#(
  parameter int W         = GCD_W,
  parameter int MAX_STEPS = 65535
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] ld_x,
  input  logic [W-1:0] ld_y,
  input  logic         step,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         zero,
  output logic         equal,
  output logic         limit
);
  localparam int CNT_W = $clog2(MAX_STEPS + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x     <= '0;
      y     <= '0;
      cnt_q <= '0;
    end else if (load) begin
      x     <= ld_x;
      y     <= ld_y;
      cnt_q <= '0;
    end else if (step) begin
      if (x > y) x <= x - y;
      else       y <= y - x;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign zero  = (x == '0) || (y == '0);
  assign equal = (x == y);
  assign limit = (cnt_q == CNT_W'(MAX_STEPS));

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin front end sharing one GCD engine; result strobes S+2 cycles after ack.
// Losing or late requesters simply stay pending: no ack is issued outside IDLE.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int W         = GCD_W,
  parameter int MAX_STEPS = 65535
) (
  input  logic         clk,
  input  logic         rst,
  gcd_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_next;
  logic [ID_W-1:0] win;
  logic            found;
  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;
  logic [W-1:0]    xw, yw;
  logic            load, step, fin, fin_err;
  logic [W-1:0]    fin_data;
  logic [W-1:0]    x, y;
  logic            zero, equal, limit;
  logic [ID_W-1:0] res_id_q;
  logic [W-1:0]    res_data_q;
  logic            res_err_q;

  // First pending requester at or above the rr pointer, wrapping at N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, rr_q} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
      idx = sum[ID_W-1:0];
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign rr_next = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
  assign xw      = bus.xi[int'(win)*W +: W];
  assign yw      = bus.yi[int'(win)*W +: W];

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    step     = 1'b0;
    fin      = 1'b0;
    fin_err  = 1'b0;
    fin_data = '0;
    case (state_q)
      IDLE: begin
        // ack is combinational, so keep it quiet while reset is asserted.
        if (found && rst) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (zero) begin
          fin = 1'b1;
        end else if (equal) begin
          fin      = 1'b1;
          fin_data = x;
        end else if (limit) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          step = 1'b1;
        end
        if (fin) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      res_id_q   <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        rr_q     <= rr_next;
        res_id_q <= win;
      end
      if (fin) begin
        res_data_q <= fin_data;
        res_err_q  <= fin_err;
      end
    end
  end

  gcd_core #(
    .W         (W),
    .MAX_STEPS (MAX_STEPS)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .ld_x  (W'(abs_mag(ABS_W'(signed'(xw))))),
    .ld_y  (W'(abs_mag(ABS_W'(signed'(yw))))),
    .step  (step),
    .x     (x),
    .y     (y),
    .zero  (zero),
    .equal (equal),
    .limit (limit)
  );

  assign bus.ack       = load ? (N_REQ'(1) << win) : '0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_id    = res_id_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter: a transaction-level model predicts every output each
// cycle, and the directed sequences pin latencies and results with hand-computed values.
module tb_gcd_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MS = 4;

  logic clk;
  logic rst;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  gcd_arbiter_if #(.N_REQ(N), .W(W)) bus ();

  gcd_arbiter #(.N_REQ(N), .W(W), .MAX_STEPS(MS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int mag(input logic signed [15:0] v);
    if (v < 0) return -int'(v);
    return int'(v);
  endfunction

  // Spec rules applied directly: zero, equal, step limit, otherwise subtract.
  function automatic void mgcd(input int a0, input int b0, output int r, output bit e, output int s);
    int a, b;
    a = a0; b = b0; s = 0; e = 0; r = 0;
    forever begin
      if (a == 0 || b == 0) begin r = 0; break; end
      if (a == b) begin r = a; break; end
      if (s == MS) begin e = 1; r = 0; break; end
      if (a > b) a -= b; else b -= a;
      s++;
    end
  endfunction

  // ---------------- model + per-cycle compare ----------------
  int   m_rr, g_cyc, d_cyc, p_id, p_data, cur_id, cur_data;
  bit   act, p_err, cur_err;
  logic [N-1:0] e_ack;
  bit   e_busy, e_valid;

  always @(negedge clk) begin
    int w, r, s;
    bit e;
    e_ack = '0; e_busy = 0; e_valid = 0;
    if (!rst) begin
      act = 0; m_rr = 0; cur_id = 0; cur_data = 0; cur_err = 0;
    end else begin
      if (act && cyc > d_cyc) act = 0;
      if (act && cyc == g_cyc + 1) cur_id = p_id;
      if (act && cyc == d_cyc) begin
        cur_data = p_data; cur_err = p_err; e_valid = 1;
      end
      e_busy = act && (cyc > g_cyc);
      if (!act && (|bus.req)) begin
        w = -1;
        for (int i = 0; i < N; i++)
          if (w < 0 && bus.req[(m_rr + i) % N]) w = (m_rr + i) % N;
        e_ack[w] = 1'b1;
        mgcd(mag(bus.xi[w*W +: W]), mag(bus.yi[w*W +: W]), r, e, s);
        act = 1; g_cyc = cyc; d_cyc = cyc + s + 2;
        p_id = w; p_data = r; p_err = e;
        m_rr = (w + 1) % N;
      end
    end
    chk("ack",       int'(bus.ack),       int'(e_ack));
    chk("busy",      int'(bus.busy),      int'(e_busy));
    chk("res_valid", int'(bus.res_valid), int'(e_valid));
    chk("res_id",    int'(bus.res_id),    cur_id);
    chk("res_data",  int'(bus.res_data),  cur_data);
    chk("res_err",   int'(bus.res_err),   int'(cur_err));
  end

  // ---------------- directed helpers ----------------
  task automatic wait_ack(input int id, output int t);
    t = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.ack[id]) begin t = cyc; break; end
    end
    if (t < 0) chk("ack_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int t, output int id, output int data, output int err);
    t = -1; id = -1; data = -1; err = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        t = cyc; id = int'(bus.res_id); data = int'(bus.res_data); err = int'(bus.res_err);
        break;
      end
    end
    if (t < 0) chk("valid_timeout", 0, 1);
  endtask

  task automatic set_ops(input int id, input int x, input int y);
    bus.xi[id*W +: W] = 16'(x);
    bus.yi[id*W +: W] = 16'(y);
  endtask

  task automatic run_job(input string nm, input int id, input int x, input int y,
                         input int exp_d, input int exp_e, input int exp_lat);
    int ta, tv, rid, rd, re;
    @(posedge clk); #1;
    set_ops(id, x, y);
    bus.req[id] = 1'b1;
    wait_ack(id, ta);
    @(posedge clk); #1;
    bus.req[id] = 1'b0;
    wait_valid(tv, rid, rd, re);
    chk({nm, "_lat"},  tv - ta, exp_lat);
    chk({nm, "_id"},   rid,     id);
    chk({nm, "_data"}, rd,      exp_d);
    chk({nm, "_err"},  re,      exp_e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r, s, ta, tv, rid, rd, re;
    bit e;
    rst = 1'b0;
    bus.req = '0; bus.xi = '0; bus.yi = '0;

    mgcd(12, 8, r, e, s);
    chk("model_12_8_r", r, 4);
    chk("model_12_8_s", s, 2);
    mgcd(100, 1, r, e, s);
    chk("model_100_1_e", int'(e), 1);
    chk("model_100_1_s", s, 4);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_data", int'(bus.res_data), 0);
    @(posedge clk); #1 rst = 1'b1;

    run_job("g12_8", 0, 12, 8, 4, 0, 4);

    // Two simultaneous requests: 1 wins, 2 waits for the first IDLE after DONE.
    @(posedge clk); #1;
    set_ops(1, 1, 3);
    set_ops(2, -36, 24);
    bus.req[1] = 1'b1; bus.req[2] = 1'b1;
    wait_ack(1, ta);
    @(posedge clk); #1 bus.req[1] = 1'b0;
    wait_valid(tv, rid, rd, re);
    chk("pair1_id", rid, 1);
    chk("pair1_data", rd, 1);
    chk("pair1_lat", tv - ta, 4);
    wait_ack(2, ta);
    chk("pair2_gap", ta - tv, 1);
    @(posedge clk); #1 bus.req[2] = 1'b0;
    wait_valid(tv, rid, rd, re);
    chk("pair2_id", rid, 2);
    chk("pair2_data", rd, 12);

    // Fairness from a fresh pointer: all requesters held continuously.
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < N; i++) set_ops(i, 6, 6);
    bus.req = '1;
    for (int k = 0; k < 5; k++) begin
      wait_ack(k % N, ta);
      if (k > 0) chk("rr_gap", ta - tv, 1);
      if (k == 4) begin
        @(posedge clk); #1 bus.req = '0;
      end
      wait_valid(tv, rid, rd, re);
      chk("rr_id", rid, k % N);
      chk("rr_data", rd, 6);
      chk("rr_lat", tv - ta, 2);
    end

    run_job("zero", 0, 0, 7, 0, 0, 2);
    run_job("minneg", 1, -32768, 16384, 16384, 0, 3);
    run_job("limit", 2, 100, 1, 0, 1, 6);

    // Reset mid-RUN discards the job; later request completes normally.
    @(posedge clk); #1;
    set_ops(3, 1000, 3);
    bus.req[3] = 1'b1;
    wait_ack(3, ta);
    @(posedge clk); #1 bus.req[3] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_id", int'(bus.res_id), 0);
    chk("midrst_err", int'(bus.res_err), 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (8) @(posedge clk);
    run_job("rereq", 3, 4, 3, 1, 0, 5);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
